// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: word width, NOP encoding, fetch FSM
// states, the IF/ID payload layout and small PC helpers.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH_FILL   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_e;

  // Contents of the IF/ID pipeline register (excluding the valid bit)
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  // Sequential next PC; wraps modulo 2^XLEN with no overflow indication
  function automatic logic [XLEN-1:0] pc_next_seq(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

  // Word alignment test for fetch targets
  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   load         capture entry and mark the stage valid
//   bubble       invalidate the stage; inst reads NOP, pc fields hold
//   entry        payload captured on load
//   valid        stage holds a real instruction
//   data         registered payload
// With neither load nor bubble asserted every field holds (stall).
module if_id_reg
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t entry,
  output logic   valid,
  output if_id_t data
);

  // Bubble wins over load so a redirect can never leak a stale instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      valid         <= 1'b0;
      data.inst     <= NOP_INST;
      data.pc       <= RESET_PC;
      data.pc_plus4 <= pc_next_seq(RESET_PC);
    end else if (bubble) begin
      valid     <= 1'b0;
      data.inst <= NOP_INST;
    end else if (load) begin
      valid <= 1'b1;
      data  <= entry;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, fetch FSM (FILL/RUN/HALTED) and the
// IF/ID pipeline register.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_stall                 hold PC and IF/ID
//   i_flush, i_redirect_pc  redirect from execute
//   i_halt                  stop fetching (sticky until reset)
//   o_imem_raddr            instruction memory address (current PC)
//   i_imem_rdata            instruction word for o_imem_raddr, same cycle
//   o_id_valid, o_id_inst, o_id_pc, o_id_pc_plus4   IF/ID register
//   o_halted                unit is halted
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_halt,
  output logic [XLEN-1:0] o_imem_raddr,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_id_valid,
  output logic [XLEN-1:0] o_id_inst,
  output logic [XLEN-1:0] o_id_pc,
  output logic [XLEN-1:0] o_id_pc_plus4,
  output logic            o_halted
);

  // PC low bits are forced to zero at reset; every later load is aligned,
  // so the PC stays word aligned by construction
  localparam logic [XLEN-1:0] RESET_PC = {RESET_ADDR[XLEN-1:2], 2'b00};

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            halted_q;
  logic            halted_d;
  logic            id_load;
  logic            id_bubble;
  if_id_t          id_entry;
  if_id_t          id_data;

  // State, PC and halted flag registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= FETCH_FILL;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // Next state, next PC and IF/ID control; priority halt > flush > stall
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    id_load   = 1'b0;
    id_bubble = 1'b0;
    unique case (state_q)
      FETCH_FILL: begin
        // One dead cycle after reset; PC stays at the reset address
        id_bubble = 1'b1;
        state_d   = i_halt ? FETCH_HALTED : FETCH_RUN;
      end
      FETCH_RUN: begin
        if (i_halt) begin
          id_bubble = 1'b1;
          state_d   = FETCH_HALTED;
        end else if (i_flush) begin
          id_bubble = 1'b1;
          // Misaligned target: freeze; the trap itself is raised downstream
          if (is_word_aligned(i_redirect_pc)) begin
            pc_d = i_redirect_pc;
          end else begin
            state_d = FETCH_HALTED;
          end
        end else if (!i_stall) begin
          id_load = 1'b1;
          pc_d    = pc_next_seq(pc_q);
        end
      end
      FETCH_HALTED: begin
        id_bubble = 1'b1;
      end
      default: begin
        id_bubble = 1'b1;
        state_d   = FETCH_FILL;
      end
    endcase
    halted_d = (state_d == FETCH_HALTED);
  end

  assign id_entry = '{inst: i_imem_rdata, pc: pc_q, pc_plus4: pc_next_seq(pc_q)};

  if_id_reg #(
    .RESET_PC (RESET_PC)
  ) u_if_id (
    .clk    (i_clk),
    .rst    (i_rst),
    .load   (id_load),
    .bubble (id_bubble),
    .entry  (id_entry),
    .valid  (o_id_valid),
    .data   (id_data)
  );

  assign o_imem_raddr  = pc_q;
  assign o_id_inst     = id_data.inst;
  assign o_id_pc       = id_data.pc;
  assign o_id_pc_plus4 = id_data.pc_plus4;
  assign o_halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/flush/halt/reset traffic, all checked against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] RA  = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] imem_raddr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        halted;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model of the fetch stage
  logic [31:0] m_pc;
  logic        m_fill;
  logic        m_halted;
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_idpc;
  logic [31:0] m_idpc4;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_ADDR(RA)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_redirect_pc (redirect_pc),
    .i_halt        (halt),
    .o_imem_raddr  (imem_raddr),
    .i_imem_rdata  (imem_rdata),
    .o_id_valid    (id_valid),
    .o_id_inst     (id_inst),
    .o_id_pc       (id_pc),
    .o_id_pc_plus4 (id_pc_plus4),
    .o_halted      (halted)
  );

  // Instruction memory: a distinct word per address
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  assign imem_rdata = imem_word(imem_raddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bubble_model();
    m_valid = 1'b0;
    m_inst  = NOP;
  endtask

  // Apply one edge's worth of inputs to the model
  task automatic model_edge(input logic r, input logic s, input logic f,
                            input logic [31:0] tgt, input logic h);
    if (r) begin
      m_pc = RA; m_fill = 1'b1; m_halted = 1'b0;
      m_valid = 1'b0; m_inst = NOP; m_idpc = RA; m_idpc4 = RA + 32'd4;
    end else if (m_halted) begin
      bubble_model();
    end else if (m_fill) begin
      m_fill = 1'b0;
      bubble_model();
      if (h) m_halted = 1'b1;
    end else if (h) begin
      m_halted = 1'b1;
      bubble_model();
    end else if (f) begin
      bubble_model();
      if (tgt[1:0] == 2'b00) m_pc = tgt;
      else m_halted = 1'b1;
    end else if (!s) begin
      m_valid = 1'b1;
      m_inst  = imem_word(m_pc);
      m_idpc  = m_pc;
      m_idpc4 = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
    end
  endtask

  task automatic check_all();
    chk("raddr", imem_raddr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    chk("id_inst", id_inst, m_inst);
    chk("id_pc", id_pc, m_idpc);
    chk("id_pc_plus4", id_pc_plus4, m_idpc4);
    chk("halted", 32'(halted), 32'(m_halted));
  endtask

  // Drive inputs for one cycle, advance the model, then check after the edge
  task automatic step(input logic r, input logic s, input logic f,
                      input logic [31:0] tgt, input logic h);
    rst = r; stall = s; flush = f; redirect_pc = tgt; halt = h;
    model_edge(r, s, f, tgt, h);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0; halt = 1'b0;

    // Reset and fill sequence
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_raddr", imem_raddr, 32'h100);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_inst", id_inst, NOP);
    chk("rst_pc", id_pc, 32'h100);
    chk("rst_pc4", id_pc_plus4, 32'h104);
    chk("rst_halted", 32'(halted), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("fill_raddr", imem_raddr, 32'h100);
    chk("fill_valid", 32'(id_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("run1_raddr", imem_raddr, 32'h104);
    chk("run1_valid", 32'(id_valid), 32'd1);
    chk("run1_pc", id_pc, 32'h100);
    step(0, 0, 0, 0, 0);
    chk("run2_raddr", imem_raddr, 32'h108);
    chk("run2_pc", id_pc, 32'h104);

    // Stall for three cycles at PC 0x208
    step(0, 0, 1, 32'h200, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("pre_stall_raddr", imem_raddr, 32'h208);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0);
      chk("stall_raddr", imem_raddr, 32'h208);
      chk("stall_pc", id_pc, 32'h204);
      chk("stall_inst", id_inst, imem_word(32'h204));
    end
    step(0, 0, 0, 0, 0);
    chk("unstall_raddr", imem_raddr, 32'h20C);

    // Flush wins over stall
    step(0, 1, 1, 32'h400, 0);
    chk("flush_raddr", imem_raddr, 32'h400);
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_inst", id_inst, NOP);
    step(0, 0, 0, 0, 0);
    chk("post_flush_pc", id_pc, 32'h400);

    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0, 0);
    chk("wrap_raddr", imem_raddr, 32'h0);
    chk("wrap_pc4", id_pc_plus4, 32'h0);

    // Halt beats flush on the same edge
    step(0, 0, 1, 32'h800, 1);
    chk("hf_halted", 32'(halted), 32'd1);
    chk("hf_raddr", imem_raddr, 32'h0);
    step(0, 0, 1, 32'h900, 0);
    chk("hf_sticky_raddr", imem_raddr, 32'h0);

    // Misaligned redirect halts; later flushes ignored; reset recovers
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h402, 0);
    chk("mis_halted", 32'(halted), 32'd1);
    chk("mis_raddr", imem_raddr, 32'h104);
    step(0, 0, 1, 32'h500, 0);
    chk("mis_ignore_raddr", imem_raddr, 32'h104);
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 32'h700, 1);
    chk("rst_override_raddr", imem_raddr, 32'h100);
    chk("rst_override_halted", 32'(halted), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("refill_raddr", imem_raddr, 32'h100);
    chk("refill_valid", 32'(id_valid), 32'd0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      logic        r, s, f, h;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 30);
      f   = ($urandom_range(0, 99) < 10);
      h   = ($urandom_range(0, 99) < 2);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      step(r, s, f, tgt, h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
